// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request fields are held stable while dmem_req is high; dmem_ack is a
// one-cycle completion pulse that qualifies dmem_rdata.
interface mem_access_stage_if #(
    parameter int AW = 32
);
    logic          dmem_req;
    logic          dmem_we;
    logic [3:0]    dmem_be;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues byte/half/word loads and stores on the data-memory
// bus, aligns/extends load data and registers the MEM/WB outputs. stall holds
// the upstream EX/MEM register for the duration of a memory access.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (adds the misalign_err output).
module mem_access_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_size,
    input  logic          load_unsigned,
    input  logic          reg_write_in,
    input  logic          mem_to_reg_in,
    input  logic [4:0]    rd_in,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] store_data,
    mem_access_stage_if.master dmem,
    output logic          stall,
    output logic          wb_reg_write,
    output logic          wb_mem_to_reg,
    output logic [4:0]    wb_rd,
    output logic [DW-1:0] wb_alu_result,
    output logic [DW-1:0] wb_load_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic          misalign_err
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_next;
    logic          mem_op, misalign, issue, bubble;
    logic [3:0]    be_c;
    logic [DW-1:0] wdata_c;

    logic          req_q, we_q;
    logic [3:0]    be_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    addr_lo_q, size_q;
    logic          unsigned_q;
    logic [DW-1:0] load_data_q, load_data_c;
    logic [7:0]    rdata_byte;
    logic [15:0]   rdata_half;

    assign mem_op = mem_read | mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((mem_size == 2'b01) && alu_result[0]) ||
                      (mem_size[1] && (alu_result[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign issue  = mem_op && !misalign;
    assign bubble = (state == IDLE) && mem_op && misalign;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    // Byte enables and lane-replicated store data from size and address.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_data;
        case (mem_size)
            2'b00: begin
                be_c    = 4'b0001 << alu_result[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_c    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select and sign/zero extension of the returned read data.
    always_comb begin
        case (addr_lo_q)
            2'd0:    rdata_byte = dmem.dmem_rdata[7:0];
            2'd1:    rdata_byte = dmem.dmem_rdata[15:8];
            2'd2:    rdata_byte = dmem.dmem_rdata[23:16];
            default: rdata_byte = dmem.dmem_rdata[31:24];
        endcase
        rdata_half  = addr_lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        load_data_c = dmem.dmem_rdata;
        case (size_q)
            2'b00: load_data_c = unsigned_q ? {24'h0, rdata_byte}
                                            : {{24{rdata_byte[7]}}, rdata_byte};
            2'b01: load_data_c = unsigned_q ? {16'h0, rdata_half}
                                            : {{16{rdata_half[15]}}, rdata_half};
            default: ;
        endcase
    end

    // Next-state and stall; stall is forced low while reset is asserted.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem.dmem_ack) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Bus request fields latched at issue; load data captured on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            load_data_q <= '0;
        end else if (state == IDLE && issue) begin
            req_q      <= 1'b1;
            we_q       <= mem_write;
            be_q       <= be_c;
            addr_q     <= {alu_result[AW-1:2], 2'b00};
            wdata_q    <= wdata_c;
            addr_lo_q  <= alu_result[1:0];
            size_q     <= mem_size;
            unsigned_q <= load_unsigned;
        end else if (state == BUSY && dmem.dmem_ack) begin
            req_q       <= 1'b0;
            load_data_q <= load_data_c;
        end
    end

    // MEM/WB register: advance when not stalled, bubble while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_load_data  <= '0;
        end else if (!stall) begin
            wb_reg_write  <= reg_write_in && !bubble;
            wb_mem_to_reg <= mem_to_reg_in && !bubble;
            wb_rd         <= rd_in;
            wb_alu_result <= alu_result;
            wb_load_data  <= load_data_q;
        end else begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // One-cycle error pulse for a trapped misaligned access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= bubble;
    end
`endif

endmodule
